// File: rtl/top_level_conv.sv
// rtl/top_level_conv.sv - 3x3 zero-padded multi-channel convolution engine with AXI-Stream in/out
// Kernels and pixels stream in, each pixel is scattered into nine accumulators, results stream out.
module top_level_conv #(
  parameter int DATA_WIDTH   = 16,
  parameter int PIXEL_WIDTH  = 16,
  parameter int KERNEL_WIDTH = 16,
  parameter int RESULT_WIDTH = 48
) (
  input  logic         clk,
  input  logic         Reset_top,
  input  logic         aresetn,
  input  logic         Load_kernel_BRAM,
  input  logic [1:0]   CHANNEL_SIZE_choose,
  input  logic [2:0]   IMAGE_SIZE_choose,
  input  logic [15:0]  bias_in,
  input  logic [255:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  input  logic         s_axis_tlast,
  output logic         s_axis_tready,
  output logic [63:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  output logic         m_axis_tlast,
  input  logic         m_axis_tready,
  output logic         ena_bias_BRAM_addr_counter,
  output logic         rst_bias_BRAM_addr_counter,
  output logic [11:0]  bias_BRAM_addr_counter_out,
  output logic         conv_DONE
);

  localparam int PROD_W = KERNEL_WIDTH + PIXEL_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_K, S_CLEAR, S_LOAD_X, S_MAC, S_OUT, S_DONE
  } state_t;

  state_t                  r_state;
  logic [7:0]              r_ch_max;
  logic [2:0]              r_log2s;
  logic [15:0]             r_bias;
  logic [7:0]              r_ch;
  logic [5:0]              r_row;
  logic [5:0]              r_col;
  logic [3:0]              r_tap;
  logic [11:0]             r_addr;
  logic [PIXEL_WIDTH-1:0]  r_pix;
  logic [63:0]             r_mdata;
  logic                    r_mvalid;
  logic                    r_mlast;
  logic                    r_done;
  logic                    r_ena;
  logic [11:0]             r_bias_addr;
  logic [KERNEL_WIDTH-1:0] r_kern [0:255][0:8];
  logic [RESULT_WIDTH-1:0] r_acc  [0:4095];

  logic [6:0]              w_s;
  logic [5:0]              w_s_m1;
  logic [11:0]             w_ss_m1;
  logic [1:0]              w_dr_off;
  logic [1:0]              w_dc_off;
  logic [7:0]              w_tr;
  logic [7:0]              w_tc;
  logic                    w_hit;
  logic [11:0]             w_mac_addr;
  logic [KERNEL_WIDTH-1:0] w_kern;
  logic [PROD_W-1:0]       w_prod;
  logic [RESULT_WIDTH-1:0] w_prod_ext;
  logic [RESULT_WIDTH-1:0] w_bias_ext;
  logic [RESULT_WIDTH-1:0] w_acc_rd;
  logic                    w_s_fire;
  logic                    w_m_fire;
  logic                    w_last_pix;
  logic                    w_unused_bits;

  assign w_s     = 7'd1 << r_log2s;
  assign w_s_m1  = 6'(w_s - 7'd1);
  assign w_ss_m1 = 12'((13'd1 << {r_log2s, 1'b0}) - 13'd1);

  // Tap k sits at kernel row k/3, column k%3; the pixel feeds the accumulator offset the opposite way.
  assign w_dr_off   = (r_tap >= 4'd6) ? 2'd2 : ((r_tap >= 4'd3) ? 2'd1 : 2'd0);
  assign w_dc_off   = 2'(r_tap - {1'b0, w_dr_off, 1'b0} - {2'b0, w_dr_off});
  assign w_tr       = {2'b0, r_row} + 8'd1 - {6'b0, w_dr_off};
  assign w_tc       = {2'b0, r_col} + 8'd1 - {6'b0, w_dc_off};
  assign w_hit      = (w_tr < {1'b0, w_s}) && (w_tc < {1'b0, w_s});
  assign w_mac_addr = 12'({4'b0, w_tr} << r_log2s) | {4'b0, w_tc};

  assign w_kern     = r_kern[r_ch][r_tap];
  assign w_prod     = {{PIXEL_WIDTH{w_kern[KERNEL_WIDTH-1]}}, w_kern}
                    * {{KERNEL_WIDTH{r_pix[PIXEL_WIDTH-1]}}, r_pix};
  assign w_prod_ext = {{(RESULT_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_bias_ext = {{(RESULT_WIDTH-24){r_bias[15]}}, r_bias, 8'b0};
  assign w_acc_rd   = r_acc[r_addr];

  assign w_last_pix = (r_col == w_s_m1) && (r_row == w_s_m1) && (r_ch == r_ch_max);
  assign w_s_fire   = s_axis_tvalid && s_axis_tready;
  assign w_m_fire   = m_axis_tvalid && m_axis_tready;
  assign w_unused_bits = ^{s_axis_tlast, s_axis_tdata[255:144]};

  assign s_axis_tready              = aresetn && ((r_state == S_LOAD_K) || (r_state == S_LOAD_X));
  assign m_axis_tvalid              = aresetn && r_mvalid;
  assign m_axis_tdata               = r_mdata;
  assign m_axis_tlast               = r_mlast;
  assign conv_DONE                  = r_done;
  assign ena_bias_BRAM_addr_counter = r_ena;
  assign rst_bias_BRAM_addr_counter = Reset_top;
  assign bias_BRAM_addr_counter_out = r_bias_addr;

  // Storage is deliberately left out of reset; its contents are rebuilt by every layer.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD_K && w_s_fire) begin
      for (int k = 0; k < 9; k++) begin
        r_kern[r_ch][k] <= s_axis_tdata[KERNEL_WIDTH*k +: KERNEL_WIDTH];
      end
    end
    if (r_state == S_CLEAR) begin
      r_acc[r_addr] <= w_bias_ext;
    end else if (r_state == S_MAC && w_hit) begin
      r_acc[w_mac_addr] <= r_acc[w_mac_addr] + w_prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset_top) begin
      r_state     <= S_IDLE;
      r_ch_max    <= 8'd0;
      r_log2s     <= 3'd2;
      r_bias      <= 16'd0;
      r_ch        <= 8'd0;
      r_row       <= 6'd0;
      r_col       <= 6'd0;
      r_tap       <= 4'd0;
      r_addr      <= 12'd0;
      r_pix       <= '0;
      r_mdata     <= 64'd0;
      r_mvalid    <= 1'b0;
      r_mlast     <= 1'b0;
      r_done      <= 1'b0;
      r_ena       <= 1'b0;
      r_bias_addr <= 12'd0;
    end else begin
      r_ena <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Load_kernel_BRAM) begin
            r_ch_max <= 8'hFF >> CHANNEL_SIZE_choose;
            r_log2s  <= (IMAGE_SIZE_choose > 3'd4) ? 3'd2 : IMAGE_SIZE_choose + 3'd2;
            r_bias   <= bias_in;
            r_ch     <= 8'd0;
            r_done   <= 1'b0;
            r_state  <= S_LOAD_K;
          end
        end
        S_LOAD_K: begin
          if (w_s_fire) begin
            if (r_ch == r_ch_max) begin
              r_ch    <= 8'd0;
              r_addr  <= 12'd0;
              r_state <= S_CLEAR;
            end else begin
              r_ch <= r_ch + 8'd1;
            end
          end
        end
        S_CLEAR: begin
          if (r_addr == w_ss_m1) begin
            r_addr  <= 12'd0;
            r_row   <= 6'd0;
            r_col   <= 6'd0;
            r_state <= S_LOAD_X;
          end else begin
            r_addr <= r_addr + 12'd1;
          end
        end
        S_LOAD_X: begin
          if (w_s_fire) begin
            r_pix   <= s_axis_tdata[DATA_WIDTH-1:0];
            r_tap   <= 4'd0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          if (r_tap == 4'd8) begin
            r_tap   <= 4'd0;
            r_state <= w_last_pix ? S_OUT : S_LOAD_X;
            if (r_col != w_s_m1) begin
              r_col <= r_col + 6'd1;
            end else begin
              r_col <= 6'd0;
              if (r_row != w_s_m1) begin
                r_row <= r_row + 6'd1;
              end else begin
                r_row <= 6'd0;
                r_ch  <= (r_ch == r_ch_max) ? 8'd0 : r_ch + 8'd1;
              end
            end
          end else begin
            r_tap <= r_tap + 4'd1;
          end
        end
        S_OUT: begin
          if (!r_mvalid) begin
            r_mdata  <= {{(64-RESULT_WIDTH){w_acc_rd[RESULT_WIDTH-1]}}, w_acc_rd};
            r_mlast  <= (r_addr == w_ss_m1);
            r_mvalid <= 1'b1;
          end else if (w_m_fire) begin
            r_mvalid <= 1'b0;
            r_mlast  <= 1'b0;
            if (r_mlast) begin
              r_addr      <= 12'd0;
              r_done      <= 1'b1;
              r_ena       <= 1'b1;
              r_bias_addr <= r_bias_addr + 12'd1;
              r_state     <= S_DONE;
            end else begin
              r_addr <= r_addr + 12'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_level_conv.sv
// tb/tb_top_level_conv.sv - self-checking bench for top_level_conv
// Outputs are compared against a gather-form convolution model computed in plain arithmetic.
module tb_top_level_conv;

  logic         clk = 1'b0;
  logic         Reset_top, aresetn, Load_kernel_BRAM;
  logic [1:0]   CHANNEL_SIZE_choose;
  logic [2:0]   IMAGE_SIZE_choose;
  logic [15:0]  bias_in;
  logic [255:0] s_axis_tdata;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic         ena_bias_BRAM_addr_counter, rst_bias_BRAM_addr_counter, conv_DONE;
  logic [11:0]  bias_BRAM_addr_counter_out;

  top_level_conv dut (
    .clk(clk), .Reset_top(Reset_top), .aresetn(aresetn), .Load_kernel_BRAM(Load_kernel_BRAM),
    .CHANNEL_SIZE_choose(CHANNEL_SIZE_choose), .IMAGE_SIZE_choose(IMAGE_SIZE_choose),
    .bias_in(bias_in), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .ena_bias_BRAM_addr_counter(ena_bias_BRAM_addr_counter),
    .rst_bias_BRAM_addr_counter(rst_bias_BRAM_addr_counter),
    .bias_BRAM_addr_counter_out(bias_BRAM_addr_counter_out), .conv_DONE(conv_DONE)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_tmo, n_unstable, done_during, extra_valid;
  logic        done_after, ena_after, ena_next;
  logic [11:0] addr_after;

  logic [15:0] kern [0:255][0:8];
  logic [15:0] pix  [0:4095];
  logic [63:0] expv [0:15];
  logic [63:0] got_d [$];
  logic        got_l [$];

  // Each output gathers every in-image neighbour pixel of every channel through the matching tap.
  function automatic void model(input int nch, input int s, input logic [15:0] bias);
    logic signed [63:0] acc;
    logic [47:0]        t;
    for (int r = 0; r < s; r++) begin
      for (int col = 0; col < s; col++) begin
        acc = longint'($signed(bias)) * 256;
        for (int c = 0; c < nch; c++)
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if (r + dr >= 0 && r + dr < s && col + dc >= 0 && col + dc < s)
                acc += longint'($signed(kern[c][(dr + 1) * 3 + dc + 1]))
                     * longint'($signed(pix[c * s * s + (r + dr) * s + col + dc]));
        t = acc[47:0];
        expv[r * s + col] = {{16{t[47]}}, t};
      end
    end
  endfunction

  task automatic start_layer(input logic [1:0] cs, input logic [2:0] is, input logic [15:0] b);
    @(negedge clk);
    CHANNEL_SIZE_choose = cs; IMAGE_SIZE_choose = is; bias_in = b; Load_kernel_BRAM = 1'b1;
    @(negedge clk);
    Load_kernel_BRAM = 1'b0;
  endtask

  task automatic send_beat(input logic [255:0] d, input int gap);
    int cnt;
    if (n_tmo > 0) return;
    @(negedge clk);
    if (gap > 0) begin
      s_axis_tvalid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = 1'($urandom);
    cnt = 0;
    while (!s_axis_tready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) n_tmo++;
    else @(posedge clk);
  endtask

  task automatic load_layer(input int nch, input int s, input int gap, input bit glitch);
    logic [255:0] d;
    for (int c = 0; c < nch; c++) begin
      for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
      for (int k = 0; k < 9; k++) d[16*k +: 16] = kern[c][k];
      send_beat(d, gap);
    end
    if (glitch) begin
      @(negedge clk);
      Load_kernel_BRAM = 1'b1; CHANNEL_SIZE_choose = 2'd0; IMAGE_SIZE_choose = 3'd4;
      @(negedge clk);
      Load_kernel_BRAM = 1'b0;
    end
    for (int i = 0; i < nch * s * s; i++) begin
      for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
      d[15:0] = pix[i];
      send_beat(d, gap);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic collect(input int n, input int period);
    int idx, cyc;
    logic held, hl;
    logic [63:0] hd;
    got_d.delete(); got_l.delete();
    n_unstable = 0; done_during = 0; extra_valid = 0;
    idx = 0; cyc = 0; held = 1'b0; hl = 1'b0; hd = 64'd0;
    while (idx < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (conv_DONE) done_during++;
      m_axis_tready = ((cyc % period) == 0);
      if (m_axis_tvalid) begin
        if (held && (m_axis_tdata !== hd || m_axis_tlast !== hl)) n_unstable++;
        if (m_axis_tready) begin
          got_d.push_back(m_axis_tdata); got_l.push_back(m_axis_tlast);
          idx++; held = 1'b0;
        end else begin
          held = 1'b1; hd = m_axis_tdata; hl = m_axis_tlast;
        end
      end else if (held) begin
        n_unstable++; held = 1'b0;
      end
    end
    if (idx < n) n_tmo++;
    @(negedge clk);
    m_axis_tready = 1'b0;
    done_after = conv_DONE; ena_after = ena_bias_BRAM_addr_counter;
    addr_after = bias_BRAM_addr_counter_out;
    @(negedge clk);
    ena_next = ena_bias_BRAM_addr_counter;
    repeat (4) begin
      if (m_axis_tvalid) extra_valid++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    Reset_top = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b exp 0", s_axis_tready); end
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b exp 0", m_axis_tvalid); end
    n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b exp 0", m_axis_tlast); end
    n_checks++; if (conv_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", conv_DONE); end
    n_checks++; if (ena_bias_BRAM_addr_counter !== 1'b0) begin n_fail++; $display("FAIL reset_ena got %b exp 0", ena_bias_BRAM_addr_counter); end
    n_checks++; if (bias_BRAM_addr_counter_out !== 12'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", bias_BRAM_addr_counter_out); end
    n_checks++; if (rst_bias_BRAM_addr_counter !== 1'b1) begin n_fail++; $display("FAIL reset_rstbias got %b exp 1", rst_bias_BRAM_addr_counter); end
    Reset_top = 1'b0;
    @(negedge clk);
    n_checks++; if (rst_bias_BRAM_addr_counter !== 1'b0) begin n_fail++; $display("FAIL release_rstbias got %b exp 0", rst_bias_BRAM_addr_counter); end
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL idle_tready got %b exp 0", s_axis_tready); end
  endtask

  task automatic test_centre_tap;
    for (int c = 0; c < 256; c++) for (int k = 0; k < 9; k++) kern[c][k] = (k == 4) ? 16'h0100 : 16'h0000;
    for (int i = 0; i < 4096; i++) pix[i] = 16'h0100;
    n_tmo = 0;
    start_layer(2'd0, 3'd0, 16'h00E1);
    load_layer(256, 4, 0, 1'b0);
    collect(16, 1);
    n_checks++; if (got_d.size() !== 16) begin n_fail++; $display("FAIL centre_count got %0d exp 16", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_checks++; if (got_d[i] !== 64'h000000000100E100) begin n_fail++; $display("FAIL centre_data[%0d] got %h exp 000000000100e100", i, got_d[i]); end
      n_checks++; if (got_l[i] !== (i == 15)) begin n_fail++; $display("FAIL centre_last[%0d] got %b exp %b", i, got_l[i], (i == 15)); end
    end
    n_checks++; if (n_tmo !== 0) begin n_fail++; $display("FAIL centre_timeout got %0d exp 0", n_tmo); end
    n_checks++; if (done_after !== 1'b1) begin n_fail++; $display("FAIL centre_done got %b exp 1", done_after); end
    n_checks++; if (ena_after !== 1'b1 || ena_next !== 1'b0) begin n_fail++; $display("FAIL centre_ena_pulse got %b%b exp 10", ena_after, ena_next); end
    n_checks++; if (addr_after !== 12'd1) begin n_fail++; $display("FAIL centre_addr got %0d exp 1", addr_after); end
    n_checks++; if (extra_valid !== 0) begin n_fail++; $display("FAIL centre_extra got %0d exp 0", extra_valid); end
  endtask

  task automatic all_taps_setup;
    for (int c = 0; c < 32; c++) for (int k = 0; k < 9; k++) kern[c][k] = 16'h0100;
    for (int i = 0; i < 512; i++) pix[i] = 16'h0100;
  endtask

  task automatic test_all_taps(input int gap, input int period, input logic [11:0] exp_addr);
    logic [63:0] e;
    int nr, nc;
    all_taps_setup();
    n_tmo = 0;
    start_layer(2'd3, 3'd0, 16'h00E1);
    load_layer(32, 4, gap, 1'b0);
    collect(16, period);
    n_checks++; if (got_d.size() !== 16) begin n_fail++; $display("FAIL taps_count(p%0d) got %0d exp 16", period, got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      nr = (i / 4 == 0 || i / 4 == 3) ? 2 : 3;
      nc = (i % 4 == 0 || i % 4 == 3) ? 2 : 3;
      e = (nr * nc == 4) ? 64'h000000000080E100 : (nr * nc == 6) ? 64'h0000000000C0E100 : 64'h000000000120E100;
      n_checks++; if (got_d[i] !== e) begin n_fail++; $display("FAIL taps_data(p%0d)[%0d] got %h exp %h", period, i, got_d[i], e); end
      n_checks++; if (got_l[i] !== (i == 15)) begin n_fail++; $display("FAIL taps_last(p%0d)[%0d] got %b", period, i, got_l[i]); end
    end
    n_checks++; if (n_unstable !== 0) begin n_fail++; $display("FAIL taps_stable(p%0d) got %0d changes exp 0", period, n_unstable); end
    n_checks++; if (n_tmo !== 0) begin n_fail++; $display("FAIL taps_timeout(p%0d) got %0d exp 0", period, n_tmo); end
    n_checks++; if (done_after !== 1'b1) begin n_fail++; $display("FAIL taps_done(p%0d) got %b exp 1", period, done_after); end
    n_checks++; if (addr_after !== exp_addr) begin n_fail++; $display("FAIL taps_addr(p%0d) got %0d exp %0d", period, addr_after, exp_addr); end
    n_checks++; if (extra_valid !== 0) begin n_fail++; $display("FAIL taps_extra(p%0d) got %0d exp 0", period, extra_valid); end
  endtask

  task automatic test_reset_mid;
    logic [255:0] d;
    all_taps_setup();
    n_tmo = 0;
    start_layer(2'd3, 3'd0, 16'h00E1);
    for (int c = 0; c < 32; c++) begin
      d = '0;
      for (int k = 0; k < 9; k++) d[16*k +: 16] = kern[c][k];
      send_beat(d, 0);
    end
    for (int i = 0; i < 20; i++) send_beat({240'd0, pix[i]}, 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL loadx_tready got %b exp 1", s_axis_tready); end
    aresetn = 1'b0;
    #1;
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL aresetn_tready got %b exp 0", s_axis_tready); end
    aresetn = 1'b1;
    Reset_top = 1'b1;
    @(negedge clk);
    n_checks++; if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL midreset_stream got %b%b%b exp 000", s_axis_tready, m_axis_tvalid, m_axis_tlast); end
    n_checks++; if (conv_DONE !== 1'b0 || ena_bias_BRAM_addr_counter !== 1'b0) begin n_fail++; $display("FAIL midreset_flags got %b%b exp 00", conv_DONE, ena_bias_BRAM_addr_counter); end
    n_checks++; if (bias_BRAM_addr_counter_out !== 12'd0) begin n_fail++; $display("FAIL midreset_addr got %0d exp 0", bias_BRAM_addr_counter_out); end
    n_checks++; if (m_axis_tdata !== 64'd0) begin n_fail++; $display("FAIL midreset_tdata got %h exp 0", m_axis_tdata); end
    Reset_top = 1'b0;
    for (int c = 0; c < 32; c++) for (int k = 0; k < 9; k++) kern[c][k] = 16'h0000;
    for (int i = 0; i < 512; i++) pix[i] = 16'($urandom);
    start_layer(2'd3, 3'd0, 16'h00E1);
    load_layer(32, 4, 0, 1'b0);
    collect(16, 1);
    n_checks++; if (got_d.size() !== 16) begin n_fail++; $display("FAIL fresh_count got %0d exp 16", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_checks++; if (got_d[i] !== 64'h000000000000E100) begin n_fail++; $display("FAIL fresh_data[%0d] got %h exp 000000000000e100", i, got_d[i]); end
      n_checks++; if (got_l[i] !== (i == 15)) begin n_fail++; $display("FAIL fresh_last[%0d] got %b", i, got_l[i]); end
    end
    n_checks++; if (n_tmo !== 0) begin n_fail++; $display("FAIL fresh_timeout got %0d exp 0", n_tmo); end
    n_checks++; if (addr_after !== 12'd1) begin n_fail++; $display("FAIL fresh_addr got %0d exp 1", addr_after); end
  endtask

  task automatic test_two_layers;
    logic [15:0] b;
    Reset_top = 1'b1;
    @(negedge clk);
    Reset_top = 1'b0;
    @(negedge clk);
    n_checks++; if (bias_BRAM_addr_counter_out !== 12'd0) begin n_fail++; $display("FAIL layers_addr0 got %0d exp 0", bias_BRAM_addr_counter_out); end
    for (int layer = 1; layer <= 2; layer++) begin
      for (int c = 0; c < 32; c++) for (int k = 0; k < 9; k++) kern[c][k] = 16'($urandom);
      for (int i = 0; i < 512; i++) pix[i] = 16'($urandom);
      b = 16'($urandom);
      model(32, 4, b);
      n_tmo = 0;
      start_layer(2'd3, (layer == 1) ? 3'd0 : 3'd5, b);
      bias_in = 16'($urandom);
      load_layer(32, 4, (layer == 1) ? 0 : 1, layer == 1);
      collect(16, (layer == 1) ? 1 : 2);
      n_checks++; if (got_d.size() !== 16) begin n_fail++; $display("FAIL layer%0d_count got %0d exp 16", layer, got_d.size()); end
      for (int i = 0; i < got_d.size(); i++) begin
        n_checks++; if (got_d[i] !== expv[i]) begin n_fail++; $display("FAIL layer%0d_data[%0d] got %h exp %h", layer, i, got_d[i], expv[i]); end
        n_checks++; if (got_l[i] !== (i == 15)) begin n_fail++; $display("FAIL layer%0d_last[%0d] got %b", layer, i, got_l[i]); end
      end
      n_checks++; if (done_during !== 0) begin n_fail++; $display("FAIL layer%0d_early_done got %0d exp 0", layer, done_during); end
      n_checks++; if (done_after !== 1'b1) begin n_fail++; $display("FAIL layer%0d_done got %b exp 1", layer, done_after); end
      n_checks++; if (addr_after !== 12'(layer)) begin n_fail++; $display("FAIL layer%0d_addr got %0d exp %0d", layer, addr_after, layer); end
      n_checks++; if (n_tmo !== 0 || n_unstable !== 0) begin n_fail++; $display("FAIL layer%0d_flow got tmo=%0d unstable=%0d exp 0", layer, n_tmo, n_unstable); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_top = 1'b1; aresetn = 1'b1; Load_kernel_BRAM = 1'b0;
    CHANNEL_SIZE_choose = 2'd0; IMAGE_SIZE_choose = 3'd0; bias_in = 16'd0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    n_tmo = 0; n_unstable = 0; done_during = 0; extra_valid = 0;
    done_after = 1'b0; ena_after = 1'b0; ena_next = 1'b0; addr_after = 12'd0;
    test_reset();
    test_centre_tap();
    test_all_taps(0, 1, 12'd2);
    test_all_taps(3, 6, 12'd3);
    test_reset_mid();
    test_two_layers();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
